// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for a given operand width; never below one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell (x - y - bin)
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial A-B with valid/ready in and out
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             borrow_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] diff_d;
    logic [CW-1:0]    cnt_d;
    logic             ovf_d;
    logic             last_bit;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_full_subtractor (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Datapath next values for one RUN step; the difference fills in from the MSB end.
    always_comb begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        last_bit = (cnt_q == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            bin_q       <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= a;
                        b_sh_q     <= b;
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
                        bin_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_d;
                    b_sh_q <= b_sh_d;
                    diff_q <= diff_d;
                    bin_q  <= bout_bit;
                    cnt_q  <= cnt_d;
                    if (last_bit) begin
                        borrow_q    <= bout_bit;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // No bypass: in_ready only rises after the result has been taken.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    logic fx, fy, fb, fd, fbo;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    full_subtractor u_fs (
        .x    (fx),
        .y    (fy),
        .bin  (fb),
        .d    (fd),
        .bout (fbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on plain integers, not on bits.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb);
        int sa, sb, sr;
        logic [W-1:0] rd;
        logic rbor, rov;
        rd   = W'((int'(ra) - int'(rb)) & ((1 << W) - 1));
        rbor = (int'(ra) < int'(rb));
        sa   = (int'(ra) >= (1 << (W - 1))) ? int'(ra) - (1 << W) : int'(ra);
        sb   = (int'(rb) >= (1 << (W - 1))) ? int'(rb) - (1 << W) : int'(rb);
        sr   = sa - sb;
        rov  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {rov, rbor, rd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake one operand pair and wait for out_valid; returns with the result visible.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit scramble,
                          output logic [W-1:0] rd, output logic rb, output logic ro, output int lat);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 40) begin
            step();
            lat++;
        end
        step();
        in_valid = scramble;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        rd = diff;
        rb = borrow;
        ro = ovf;
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [W-1:0] rd, input logic rb, input logic ro);
        logic [W+1:0] e;
        e = ref_sub(ia, ib);
        checks++;
        if ({ro, rb, rd} !== e) begin
            errors++;
            $display("FAIL %s a=%h b=%h got diff=%h borrow=%b ovf=%b exp diff=%h borrow=%b ovf=%b",
                     name, ia, ib, rd, rb, ro, e[W-1:0], e[W], e[W+1]);
        end
    endtask

    task automatic test_full_subtractor();
        for (int i = 0; i < 8; i++) begin
            int r;
            fx = i[2];
            fy = i[1];
            fb = i[0];
            #1;
            r = int'(fx) - int'(fy) - int'(fb);
            checks++;
            if ({fbo, fd} !== {(r < 0), r[0]}) begin
                errors++;
                $display("FAIL fs x=%b y=%b bin=%b got d=%b bout=%b exp d=%b bout=%b",
                         fx, fy, fb, fd, fbo, r[0], (r < 0));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, diff, borrow, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got in_ready=%b out_valid=%b diff=%h borrow=%b ovf=%b exp 1 0 00 0 0",
                     in_ready, out_valid, diff, borrow, ovf);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] rd;
        logic rb, ro;
        int lat;
        out_ready = 1'b1;
        run_op(8'h5A, 8'h3C, 1'b0, rd, rb, ro, lat);
        check_result("basic", 8'h5A, 8'h3C, rd, rb, ro);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL latency got %0d exp 8", lat);
        end
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL basic_idle got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] rd;
        logic rb, ro;
        int lat;
        out_ready = 1'b1;
        run_op(8'h00, 8'h01, 1'b0, rd, rb, ro, lat);
        check_result("borrow_edge", 8'h00, 8'h01, rd, rb, ro);
        step();
        run_op(8'h80, 8'h01, 1'b0, rd, rb, ro, lat);
        check_result("ovf_edge", 8'h80, 8'h01, rd, rb, ro);
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rd;
        logic rb, ro;
        int lat;
        out_ready = 1'b0;
        run_op(8'h10, 8'h10, 1'b0, rd, rb, ro, lat);
        check_result("bp_result", 8'h10, 8'h10, rd, rb, ro);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({in_ready, out_valid, diff, borrow, ovf} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got in_ready=%b out_valid=%b diff=%h borrow=%b ovf=%b exp 0 1 00 0 0",
                         i, in_ready, out_valid, diff, borrow, ovf);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        int n_in = 0;
        int n_out = 0;
        int cyc = 0;
        int last_hs = -1;
        bit hs, ov;
        logic [W-1:0] sd;
        logic sb, so;
        out_ready = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        in_valid = 1'b1;
        while (n_out < 200 && cyc < 3000) begin
            hs = in_valid && in_ready;
            ov = out_valid;
            sd = diff;
            sb = borrow;
            so = ovf;
            step();
            cyc++;
            if (hs) begin
                qa.push_back(a);
                qb.push_back(b);
                if (last_hs >= 0) begin
                    checks++;
                    if (cyc - last_hs !== 10) begin
                        errors++;
                        $display("FAIL b2b_interval got %0d exp 10", cyc - last_hs);
                    end
                end
                last_hs = cyc;
                n_in++;
                a = W'($urandom);
                b = W'($urandom);
                if (n_in >= 200) in_valid = 1'b0;
            end
            if (ov) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_spurious got result with no pending operands exp none");
                end else begin
                    check_result("b2b", qa.pop_front(), qb.pop_front(), sd, sb, so);
                end
                n_out++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_out !== 200) begin
            errors++;
            $display("FAIL b2b_count got %0d results exp 200", n_out);
        end
        step();
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] rd;
        logic rb, ro;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        a = 8'hC3;
        b = 8'h5E;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort got in_ready=%b out_valid=%b diff=%h exp 1 0 00", in_ready, out_valid, diff);
        end
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d out_valid cycles exp 0", seen);
        end
        run_op(8'h37, 8'hA9, 1'b0, rd, rb, ro, lat);
        check_result("after_abort", 8'h37, 8'hA9, rd, rb, ro);
        step();
    endtask

    task automatic test_ignore_during_run();
        logic [W-1:0] rd;
        logic rb, ro;
        int lat;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] ia, ib;
            ia = W'($urandom);
            ib = W'($urandom);
            run_op(ia, ib, 1'b1, rd, rb, ro, lat);
            check_result("ignore_run", ia, ib, rd, rb, ro);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        fx = 1'b0;
        fy = 1'b0;
        fb = 1'b0;
        test_full_subtractor();
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_ignore_during_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes A − B LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It returns the difference, the borrow-out and the signed-overflow flag over a second valid/ready handshake. It is the subtracting counterpart of the team's full-adder arithmetic cells, intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  sole clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, sampled on input handshake.
- b  input  WIDTH  subtrahend, sampled on input handshake.
- out_valid  output  1  diff/borrow/ovf are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).
- ovf  output  1  signed overflow of a − b.

## Operation
- One clock domain, clk; synchronous, active-high reset rst.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: both 0.
  - DONE: in_ready=0, out_valid=1.
- Transitions:
  - IDLE→RUN on in_valid && in_ready.
  - RUN→DONE when the bit counter reaches WIDTH−1 and that bit is processed.
  - DONE→IDLE on out_valid && out_ready.
- On input handshake:
  - Latch a and b into shift registers.
  - Clear borrow flop to 0 and bit counter to 0.
  - Capture a[WIDTH−1] and b[WIDTH−1] for the overflow calculation.
- Each RUN cycle, with x = a_sh[0], y = b_sh[0], bin = borrow flop:
  - d = x ^ y ^ bin; bout = (~x & y) | (~x & bin) | (y & bin).
  - d shifts into diff at MSB, diff shifts right.
  - a_sh and b_sh shift right; borrow flop ← bout; counter increments.
- On the final RUN cycle:
  - borrow output ← bout of bit WIDTH−1.
  - ovf ← (a_msb != b_msb) && (d != a_msb).
- diff, borrow and ovf are meaningful only while out_valid=1. diff changes during RUN. All three hold stable through DONE until the output handshake.
- No input acceptance while RUN or DONE: in_ready is 0. No same-cycle bypass from DONE to accepting new operands.
- in_valid while not ready is ignored. The source must hold a/b until the handshake.
- Reset values: in_ready=1 (IDLE), out_valid=0, diff=0, borrow=0, ovf=0, counter=0.
- rst mid-RUN or in DONE:
  - Aborts the operation and returns to IDLE.
  - No out_valid pulse is produced for the aborted operation.
  - rst has priority over every handshake in the same cycle.

## Timing
- Input handshake at edge E0 → RUN for edges E1..E_WIDTH → out_valid=1 visible after edge E_WIDTH.
- Latency: WIDTH cycles from input handshake to out_valid.
- With out_ready held high:
  - Output handshake occurs at E_WIDTH+1.
  - in_ready is visible after that edge.
  - Next input handshake occurs at E_WIDTH+2.
  - Sustained throughput is one operation per WIDTH+2 cycles.
- out_ready low: DONE holds indefinitely with outputs stable and in_ready=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Counter width = $clog2(WIDTH).
- Sub-module full_subtractor:
  - Ports: x, y, bin → d, bout.
  - Purely combinational, instantiated once.
  - Also unit-tested exhaustively on its own, all 8 input combinations.
- Top level holds the FSM, bit counter, shift registers, borrow flop and the result registers.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x3C → diff=0x1E, borrow=0, ovf=0; out_valid exactly 8 cycles after the handshake.
- a=0x00, b=0x01 → diff=0xFF, borrow=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1.
- Back-pressure, a=0x10, b=0x10: hold out_ready=0 for 5 cycles after out_valid → diff=0x00, borrow=0, ovf=0 stable, in_ready=0 throughout. Raise out_ready → IDLE next cycle.
- Back-to-back: in_valid continuously high with out_ready=1 → one handshake every 10 cycles. Compare 200 random pairs against a reference model (a−b, a<b, signed overflow).
- Assert rst 3 cycles into RUN → next cycle in_ready=1, out_valid=0, diff=0. No result is produced for the aborted operands. The next operation computes correctly.
- Drive in_valid with changing a/b during RUN → ignored; result reflects the operands latched at the handshake.
